// File: rtl/cla_pkg.sv
// cla_pkg: shared types and sizing helper for the pipelined CLA adder/subtractor
package cla_pkg;
  typedef enum logic {OP_ADD, OP_SUB} cla_op_e;
  typedef struct packed {logic p; logic g;} cla_pg_t;
  function automatic int cla_groups(input int width, input int block);
    return width / block;
  endfunction
endpackage

// File: rtl/cla_group_nbit.sv
// cla_group_nbit: BLOCK-bit lookahead group; a/b/cin in, sum plus group propagate p and generate g out
module cla_group_nbit #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             p,
  output logic             g
);
  logic [BLOCK-1:0] bp, bg, c;
  assign bp = a ^ b;
  assign bg = a & b;
  assign sum = bp ^ c;
  always_comb begin
    c = '0;
    c[0] = cin;
    for (int i = 0; i < BLOCK - 1; i++) c[i+1] = bg[i] | bp[i] & c[i];
    p = &bp;
    g = 1'b0;
    for (int i = 0; i < BLOCK; i++) g = bg[i] | bp[i] & g;
  end
endmodule

// File: rtl/pipelined_cla_addsub.sv
// pipelined_cla_addsub: elastic STAGES-deep carry-lookahead add/sub.
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_a/in_b/in_cin/in_sub beat in;
// out_valid/out_ready/out_sum/out_cout result out. PIPELINED_CLA_FLAGS_EN adds out_zero/out_neg/out_ovf.
module pipelined_cla_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef PIPELINED_CLA_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf
`endif
);
  localparam int G   = cla_groups(WIDTH, BLOCK);
  localparam int GPS = G / STAGES;
  localparam int SW  = GPS * BLOCK;
  localparam int L   = STAGES - 1;
  if (WIDTH % BLOCK != 0 || STAGES < 1 || STAGES > G || G % STAGES != 0) begin : g_bad_cfg
    $error("pipelined_cla_addsub: WIDTH/BLOCK/STAGES combination not supported");
  end
  logic             sub;
  logic [STAGES-1:0] v, vi, ld, ci, co, c_q;
  logic [WIDTH-1:0] ai [STAGES];
  logic [WIDTH-1:0] bi [STAGES];
  logic [WIDTH-1:0] si [STAGES];
  logic [WIDTH-1:0] sd [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic [G-1:0]     gcin;
  cla_pg_t [G-1:0]  gpg;
  logic [WIDTH-1:0] gsum;
  assign sub = cla_op_e'(in_sub) == OP_SUB;
  // Stage s works on the operands/partial sum held by stage s-1; ld[s] means stage s may load.
  always_comb begin
    ai[0] = in_a;
    bi[0] = sub ? ~in_b : in_b;
    ci[0] = sub | in_cin;
    si[0] = '0;
    vi[0] = in_valid;
    for (int s = 1; s < STAGES; s++) begin
      ai[s] = a_q[s-1];
      bi[s] = b_q[s-1];
      ci[s] = c_q[s-1];
      si[s] = s_q[s-1];
      vi[s] = v[s-1];
    end
    ld = '0;
    ld[L] = !v[L] | out_ready;
    for (int s = L - 1; s >= 0; s--) ld[s] = !v[s] | ld[s+1];
  end
  // Group carries from group P/G; the unrolled chain flattens into two-level lookahead per stage.
  always_comb begin
    logic run;
    run = 1'b0;
    gcin = '0;
    co = '0;
    for (int g = 0; g < G; g++) begin
      gcin[g] = (g % GPS == 0) ? ci[g/GPS] : run;
      run = gpg[g].g | gpg[g].p & gcin[g];
      co[g/GPS] = run;
    end
  end
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      sd[s] = si[s];
      sd[s][s*SW +: SW] = gsum[s*SW +: SW];
    end
  end
  for (genvar i = 0; i < G; i++) begin : g_grp
    cla_group_nbit #(.BLOCK(BLOCK)) u_grp (
      .a  (ai[i/GPS][i*BLOCK +: BLOCK]),
      .b  (bi[i/GPS][i*BLOCK +: BLOCK]),
      .cin(gcin[i]),
      .sum(gsum[i*BLOCK +: BLOCK]),
      .p  (gpg[i].p),
      .g  (gpg[i].g)
    );
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      c_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        a_q[s] <= '0;
        b_q[s] <= '0;
        s_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (ld[s]) begin
          v[s] <= vi[s];
          a_q[s] <= ai[s];
          b_q[s] <= bi[s];
          s_q[s] <= sd[s];
          c_q[s] <= co[s];
        end
      end
    end
  end
  assign in_ready  = ld[0];
  assign out_valid = v[L];
  assign out_sum   = s_q[L];
  assign out_cout  = c_q[L];
`ifdef PIPELINED_CLA_FLAGS_EN
  // Carry into the MSB is recovered as sum ^ a ^ b at that bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_zero <= 1'b0;
      out_neg <= 1'b0;
      out_ovf <= 1'b0;
    end else if (ld[L]) begin
      out_zero <= sd[L] == '0;
      out_neg <= sd[L][WIDTH-1];
      out_ovf <= co[L] ^ sd[L][WIDTH-1] ^ ai[L][WIDTH-1] ^ bi[L][WIDTH-1];
    end
  end
`endif
endmodule
